// File: rtl/signal_field_parser_if.sv
// Bit-serial input and parsed-result bundle of the 802.11a SIGNAL field parser.
// The master side feeds decoded bits; the slave side is the parser itself.
interface signal_field_parser_if;
   logic        start;
   logic        bit_in;
   logic        bit_valid;
   logic        busy;
   logic [4:0]  bit_idx;
   logic        done;
   logic [3:0]  rate;
   logic [11:0] length;
   logic [7:0]  ndbps;
   logic        rate_ok;
   logic        parity_ok;
   logic        reserved_ok;
   logic        tail_ok;
   logic        sig_ok;

   modport master (
      output start, bit_in, bit_valid,
      input  busy, bit_idx, done, rate, length, ndbps,
      input  rate_ok, parity_ok, reserved_ok, tail_ok, sig_ok
   );

   modport slave (
      input  start, bit_in, bit_valid,
      output busy, bit_idx, done, rate, length, ndbps,
      output rate_ok, parity_ok, reserved_ok, tail_ok, sig_ok
   );
endinterface

// File: rtl/signal_field_parser.sv
// RX-side 802.11a SIGNAL field parser: collects 24 decoded bits, first bit first,
// then reports RATE, LENGTH, N_DBPS and the parity/reserved/tail checks.
module signal_field_parser #(
   parameter bit CHECK_TAIL = 1'b1
) (
   input logic            clk,
   input logic            rst,
   signal_field_parser_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      REPORT  = 2'd2
   } state_t;

   state_t      state;
   logic [23:0] shreg;
   logic [4:0]  idx;
   logic        busy;
   logic        done;
   logic [3:0]  rate;
   logic [11:0] length;
   logic [7:0]  ndbps;
   logic        rate_ok;
   logic        parity_ok;
   logic        reserved_ok;
   logic        tail_ok;
   logic        sig_ok;

   logic [23:0] fld;
   logic [3:0]  dec_rate;
   logic [11:0] dec_length;
   logic [7:0]  dec_ndbps;
   logic        dec_rate_ok;
   logic        dec_parity_ok;
   logic        dec_reserved_ok;
   logic        dec_tail_ok;

   function automatic logic [7:0] rate_to_ndbps(input logic [3:0] r);
      logic [7:0] n;
      case (r)
         4'b1101: n = 8'd24;
         4'b1111: n = 8'd36;
         4'b0101: n = 8'd48;
         4'b0111: n = 8'd72;
         4'b1001: n = 8'd96;
         4'b1011: n = 8'd144;
         4'b0001: n = 8'd192;
         4'b0011: n = 8'd216;
         default: n = 8'd0;
      endcase
      return n;
   endfunction

   function automatic logic rate_legal(input logic [3:0] r);
      logic ok;
      case (r)
         4'b1101, 4'b1111, 4'b0101, 4'b0111,
         4'b1001, 4'b1011, 4'b0001, 4'b0011: ok = 1'b1;
         default:                            ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic even_parity_ok(input logic [17:0] b);
      return ~(^b);
   endfunction

   // Decode of the complete field as it stands when the 24th bit arrives.
   always_comb begin
      // shreg[23] is cleared on start, so OR-ing in the live bit completes the field.
      fld             = shreg | {bus.bit_in, 23'd0};
      dec_rate        = {fld[0], fld[1], fld[2], fld[3]};
      dec_length      = fld[16:5];
      dec_ndbps       = rate_to_ndbps(dec_rate);
      dec_rate_ok     = rate_legal(dec_rate);
      dec_parity_ok   = even_parity_ok(fld[17:0]);
      dec_reserved_ok = ~fld[4];
      if (CHECK_TAIL) begin
         dec_tail_ok = (fld[23:18] == 6'd0);
      end else begin
         dec_tail_ok = 1'b1;
      end
   end

   // Control FSM, bit capture and registered result outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         shreg       <= 24'd0;
         idx         <= 5'd0;
         busy        <= 1'b0;
         done        <= 1'b0;
         rate        <= 4'd0;
         length      <= 12'd0;
         ndbps       <= 8'd0;
         rate_ok     <= 1'b0;
         parity_ok   <= 1'b0;
         reserved_ok <= 1'b0;
         tail_ok     <= 1'b0;
         sig_ok      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (bus.start) begin
            // Restart wins in every state; a bit presented alongside start is dropped.
            state <= COLLECT;
            shreg <= 24'd0;
            idx   <= 5'd0;
            busy  <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  state <= IDLE;
                  idx   <= 5'd0;
                  busy  <= 1'b0;
               end
               COLLECT: begin
                  if (bus.bit_valid) begin
                     shreg[idx] <= bus.bit_in;
                     if (idx == 5'd23) begin
                        state       <= REPORT;
                        idx         <= 5'd0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        rate        <= dec_rate;
                        length      <= dec_length;
                        ndbps       <= dec_ndbps;
                        rate_ok     <= dec_rate_ok;
                        parity_ok   <= dec_parity_ok;
                        reserved_ok <= dec_reserved_ok;
                        tail_ok     <= dec_tail_ok;
                        sig_ok      <= dec_rate_ok & dec_parity_ok &
                                       dec_reserved_ok & dec_tail_ok;
                     end else begin
                        idx <= idx + 5'd1;
                     end
                  end else begin
                     idx <= idx;
                  end
               end
               REPORT: begin
                  state <= IDLE;
                  idx   <= 5'd0;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= IDLE;
                  idx   <= 5'd0;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.busy        = busy;
   assign bus.bit_idx     = idx;
   assign bus.done        = done;
   assign bus.rate        = rate;
   assign bus.length      = length;
   assign bus.ndbps       = ndbps;
   assign bus.rate_ok     = rate_ok;
   assign bus.parity_ok   = parity_ok;
   assign bus.reserved_ok = reserved_ok;
   assign bus.tail_ok     = tail_ok;
   assign bus.sig_ok      = sig_ok;

endmodule
